// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encodings, word/address widths
// and the first-byte nibble rule.
package program_loader_pkg;

  localparam int INSTR_WIDTH = 28;
  localparam int ADDR_WIDTH  = 16;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  // The first byte of a word carries the top 8 bits; only the low nibble fits in 28 bits.
  function automatic logic first_byte_ok(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/loader_byte_assembler.sv
// Collects stream bytes into a 32-bit word, tracks byte position within the word
// and keeps the running XOR checksum of every byte shifted in.
module loader_byte_assembler (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  byte_cnt_o,
  output logic [7:0]  xor_o
);

  logic [31:0] word_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  xor_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
      xor_q      <= '0;
    end else if (shift_i) begin
      word_q     <= {word_q[23:0], byte_i};
      byte_cnt_q <= byte_cnt_q + 2'd1;
      xor_q      <= xor_q ^ byte_i;
    end
  end

  assign word_o     = word_q;
  assign byte_cnt_o = byte_cnt_q;
  assign xor_o      = xor_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses count, instruction words and checksum,
// writes words into instruction RAM and releases the CPU only on a clean load.
//
// state    | meaning
// S_CNT_HI | waiting for count high byte
// S_CNT_LO | waiting for count low byte, range-checks N
// S_DATA   | assembling instruction words, one strobe per word
// S_CHECK  | waiting for checksum byte
// S_DONE   | load good, CPU released (sticky)
// S_ERROR  | load rejected (sticky)
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iDataValid,
  input  logic [7:0]             iData,
  output logic                   oDataReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oWriteInstruction,
  output logic                   oCpuReset,
  output logic                   oDone,
  output logic                   oError
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_e state_q, state_d;

  logic [7:0]             cnt_hi_q;
  logic [15:0]            count_q;
  logic [ADDR_WIDTH-1:0]  word_idx_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [INSTR_WIDTH-1:0] instr_q;

  logic        accept;
  logic        in_data;
  logic        shift;
  logic        word_complete;
  logic        last_word;
  logic [15:0] n_d;
  logic [31:0] asm_word;
  logic [1:0]  asm_cnt;
  logic [7:0]  asm_xor;
  logic [31:0] full_word;

  assign accept        = iDataValid && oDataReady;
  assign in_data       = accept && (state_q == S_DATA);
  assign shift         = in_data && ((asm_cnt != 2'd0) || first_byte_ok(iData));
  assign word_complete = in_data && (asm_cnt == 2'd3);
  assign last_word     = (word_idx_q == (count_q - 16'd1));
  assign n_d           = {cnt_hi_q, iData};
  assign full_word     = {asm_word[23:0], iData};

  loader_byte_assembler u_asm (
    .Clock      (Clock),
    .Reset      (Reset),
    .shift_i    (shift),
    .byte_i     (iData),
    .word_o     (asm_word),
    .byte_cnt_o (asm_cnt),
    .xor_o      (asm_xor)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_CNT_HI;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CNT_HI: if (accept) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          if (n_d == 16'd0)               state_d = S_CHECK;
          else if ({1'b0, n_d} > MAX_W)   state_d = S_ERROR;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          if ((asm_cnt == 2'd0) && !first_byte_ok(iData)) state_d = S_ERROR;
          else if ((asm_cnt == 2'd3) && last_word)       state_d = S_CHECK;
        end
      end
      S_CHECK: if (accept) state_d = (iData == asm_xor) ? S_DONE : S_ERROR;
      default: state_d = state_q;
    endcase
  end

  // The strobe is gated by Reset so a write pending in the reset cycle never reaches RAM.
  always_comb begin
    oDataReady   = 1'b0;
    oCpuReset    = 1'b1;
    oDone        = 1'b0;
    oError       = 1'b0;
    oWriteEnable = we_q && !Reset;
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK: oDataReady = 1'b1;
      S_DONE: begin
        oCpuReset = 1'b0;
        oDone     = 1'b1;
      end
      S_ERROR: oError = 1'b1;
      default: oDataReady = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_hi_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept && (state_q == S_CNT_HI)) cnt_hi_q <= iData;
      if (accept && (state_q == S_CNT_LO)) count_q <= n_d;
      if (word_complete) begin
        we_q       <= 1'b1;
        addr_q     <= word_idx_q;
        instr_q    <= full_word[INSTR_WIDTH-1:0];
        word_idx_q <= word_idx_q + 1'b1;
      end
    end
  end

  assign oWriteAddress     = addr_q;
  assign oWriteInstruction = instr_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream-level model predicts RAM writes
// and final status; a negedge monitor checks every write strobe against the queue.
module tb_program_loader;

  localparam int MAXW = 256;

  typedef struct {
    logic [15:0] addr;
    logic [27:0] instr;
  } wr_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iDataValid = 1'b0;
  logic [7:0]  iData = 8'h00;
  logic        oDataReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oWriteInstruction;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  int vectors = 0;
  int miscompares = 0;
  wr_t exp_q[$];
  int strobes_seen = 0;
  logic prev_we = 1'b0;
  logic [27:0] last_instr = '0;
  logic [15:0] last_addr = '0;

  program_loader #(.MAX_WORDS(MAXW)) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .iDataValid        (iDataValid),
    .iData             (iData),
    .oDataReady        (oDataReady),
    .oWriteEnable      (oWriteEnable),
    .oWriteAddress     (oWriteAddress),
    .oWriteInstruction (oWriteInstruction),
    .oCpuReset         (oCpuReset),
    .oDone             (oDone),
    .oError            (oError)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge Clock) begin
    if (oWriteEnable) begin
      strobes_seen++;
      last_instr = oWriteInstruction;
      last_addr  = oWriteAddress;
      check("strobe_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: addr %h instr %h, none expected", oWriteAddress, oWriteInstruction);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {16'd0, oWriteAddress}, {16'd0, e.addr});
        check("write_instr", {4'd0, oWriteInstruction}, {4'd0, e.instr});
      end
    end
    prev_we = oWriteEnable;
  end

  // Stream-level reference: outcome 0 = incomplete, 1 = done, 2 = error.
  task automatic model(input logic [7:0] s[$], output int outcome);
    int n;
    logic [7:0] x;
    wr_t w;
    outcome = 0;
    if (s.size() < 2) return;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n > MAXW) begin
      outcome = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (2 + 4*i >= s.size()) return;
      if (s[2+4*i] > 8'h0F) begin
        outcome = 2;
        return;
      end
      if (2 + 4*i + 3 >= s.size()) return;
      w.addr  = 16'(i);
      w.instr = {s[2+4*i][3:0], s[3+4*i], s[4+4*i], s[5+4*i]};
      exp_q.push_back(w);
      x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
    end
    if (2 + 4*n >= s.size()) return;
    outcome = (s[2+4*n] == x) ? 1 : 2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    while (int'($urandom_range(99)) < gap_pct) begin
      iDataValid = 1'b0;
      iData = 8'($urandom);
      @(negedge Clock);
    end
    iDataValid = 1'b1;
    iData = b;
    @(negedge Clock);
    iDataValid = 1'b0;
  endtask

  task automatic check_status(input string tag, input int outcome);
    check({tag, "_done"},   {31'd0, oDone},      {31'd0, outcome == 1});
    check({tag, "_error"},  {31'd0, oError},     {31'd0, outcome == 2});
    check({tag, "_cpurst"}, {31'd0, oCpuReset},  {31'd0, outcome != 1});
    check({tag, "_ready"},  {31'd0, oDataReady}, {31'd0, outcome == 0});
  endtask

  task automatic run_load(input string tag, input logic [7:0] s[$], input int gap_pct);
    int outcome;
    model(s, outcome);
    foreach (s[i]) send_byte(s[i], gap_pct);
    repeat (3) @(negedge Clock);
    check_status(tag, outcome);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rst_ready"}, {31'd0, oDataReady},   32'd1);
    check({tag, "_rst_we"},    {31'd0, oWriteEnable}, 32'd0);
    check({tag, "_rst_addr"},  {16'd0, oWriteAddress}, 32'd0);
    check({tag, "_rst_instr"}, {4'd0, oWriteInstruction}, 32'd0);
    check({tag, "_rst_cpu"},   {31'd0, oCpuReset},    32'd1);
    check({tag, "_rst_done"},  {31'd0, oDone},        32'd0);
    check({tag, "_rst_err"},   {31'd0, oError},       32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    iDataValid = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic build_load(output logic [7:0] s[$], input int n, input bit bad_sum, input int bad_word);
    logic [7:0] x, b;
    s = {};
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        if (k == 0) b = (i == bad_word) ? {4'($urandom_range(15, 1)), b[3:0]} : {4'h0, b[3:0]};
        s.push_back(b);
        x ^= b;
      end
    end
    s.push_back(bad_sum ? ~x : x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    int n0;
    int base;

    do_reset();
    check_reset_values("init");

    // Single-word load with a known checksum.
    s = {8'h00, 8'h01, 8'h00, 8'h01, 8'h0F, 8'hA0, 8'hAE};
    run_load("n1", s, 0);
    check("n1_instr_const", {4'd0, last_instr}, 32'h0010FA0);
    check("n1_addr_const", {16'd0, last_addr}, 32'd0);
    do_reset();

    // Three words with random valid gaps.
    build_load(s, 3, 1'b0, -1);
    base = strobes_seen;
    run_load("n3_gaps", s, 40);
    check("n3_strobe_count", 32'(strobes_seen - base), 32'd3);
    do_reset();

    // Bad checksum: one write, sticky error, trailing bytes ignored.
    s = {8'h00, 8'h01, 8'h00, 8'h01, 8'h0F, 8'hA0, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    base = strobes_seen;
    run_load("badsum", s, 0);
    check("badsum_strobe_count", 32'(strobes_seen - base), 32'd1);
    do_reset();

    // Count overflow.
    n0 = MAXW + 1;
    s = {8'(n0 >> 8), 8'(n0), 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    base = strobes_seen;
    run_load("overflow", s, 0);
    check("overflow_no_strobe", 32'(strobes_seen - base), 32'd0);
    do_reset();

    // Bad nibble on the first word.
    s = {8'h00, 8'h02, 8'h10, 8'h22, 8'h33, 8'h44};
    base = strobes_seen;
    model(s, n0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    check_status("nibble_immediate", 2);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    repeat (2) @(negedge Clock);
    check("nibble_no_strobe", 32'(strobes_seen - base), 32'd0);
    check_status("nibble_sticky", n0);
    exp_q.delete();
    do_reset();

    // Largest legal count.
    build_load(s, MAXW, 1'b0, -1);
    run_load("nmax", s, 5);
    do_reset();

    // Randomized loads.
    for (int t = 0; t < 12; t++) begin
      int sel;
      sel = int'($urandom_range(3));
      build_load(s, int'($urandom_range(5)), sel == 1, (sel == 2) ? int'($urandom_range(4)) : -1);
      run_load("rand", s, int'($urandom_range(50)));
      do_reset();
    end

    // Reset in the cycle after the 4th word byte: strobe suppressed.
    s = {8'h00, 8'h01, 8'h00, 8'h01, 8'h0F};
    foreach (s[i]) send_byte(s[i], 0);
    iDataValid = 1'b1;
    iData = 8'hA0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    iDataValid = 1'b0;
    base = strobes_seen;
    @(negedge Clock);
    check("rst_strobe_suppressed", {31'd0, oWriteEnable}, 32'd0);
    @(negedge Clock);
    check_reset_values("midload");
    Reset = 1'b0;
    s = {8'h00, 8'h00, 8'h00};
    run_load("after_rst_n0", s, 0);
    check("rst_no_strobe", 32'(strobes_seen - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
